// File: rtl/matrix_slot_allocator.sv
// Matrix slot allocator: hands out fixed-size slots in the shared matrix RAM
// to the input stage, and resolves "k-th matrix of size m x n" lookups for
// the compute FSM. Scans always visit every slot, so latency is fixed.

// One table entry: valid bit plus the matrix shape stored in the slot.
module matrix_slot_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_i,      // commit: mark valid with m_i/n_i
    input  logic       clr_i,      // invalidate (clear_all or victim)
    input  logic [2:0] m_i,
    input  logic [2:0] n_i,
    output logic       valid_o,
    output logic       valid_d_o,  // next-state valid, used for the popcount
    output logic [2:0] m_o,
    output logic [2:0] n_o
);
    logic       valid_q;
    logic [2:0] m_q, n_q;

    // A commit landing together with a clear keeps the freshly written matrix.
    assign valid_d_o = set_i ? 1'b1 : (clr_i ? 1'b0 : valid_q);
    assign valid_o   = valid_q;
    assign m_o       = m_q;
    assign n_o       = n_q;

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
        end else begin
            valid_q <= valid_d_o;
            if (set_i) begin
                m_q <= m_i;
                n_q <= n_i;
            end
        end
    end
endmodule

module matrix_slot_allocator #(
    parameter int NUM_SLOTS  = 16,
    parameter int SLOT_WORDS = 25,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    input  logic [2:0]        alloc_m,
    input  logic [2:0]        alloc_n,
    input  logic              commit,
    input  logic              abort,
    input  logic              clear_all,
    input  logic              q_req,
    input  logic [2:0]        q_m,
    input  logic [2:0]        q_n,
    input  logic [1:0]        q_idx,
    output logic              addr_ready,
    output logic [ADDR_W-1:0] base_addr,
    output logic              q_done,
    output logic              q_found,
    output logic [ADDR_W-1:0] q_base,
    output logic              busy,
    output logic [4:0]        mat_count
);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {IDLE, A_SCAN, GRANT, FILL, Q_SCAN, Q_DONE} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  scan_q, free_idx_q, rr_q, pend_idx_q, qhit_idx_q;
    logic              found_q, qhit_q;
    logic [2:0]        pend_m_q, pend_n_q, qm_q, qn_q;
    logic [1:0]        qidx_q;
    logic [IDX_W:0]    qcnt_q;
    logic              addr_ready_q, q_done_q, q_found_q, busy_q;
    logic [ADDR_W-1:0] base_addr_q, q_base_q;
    logic [4:0]        mat_count_q;

    logic [NUM_SLOTS-1:0]      slot_valid, slot_valid_d, slot_set, slot_clr;
    logic [NUM_SLOTS-1:0][2:0] slot_m, slot_n;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [IDX_W-1:0] idx);
        return ADDR_W'(idx) * ADDR_W'(SLOT_WORDS);
    endfunction

    // Slot table.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        matrix_slot_entry u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .set_i    (slot_set[i]),
            .clr_i    (slot_clr[i]),
            .m_i      (pend_m_q),
            .n_i      (pend_n_q),
            .valid_o  (slot_valid[i]),
            .valid_d_o(slot_valid_d[i]),
            .m_o      (slot_m[i]),
            .n_o      (slot_n[i])
        );
    end

    // Scan datapath: the slot under the scan pointer is folded in
    // combinationally so the last scan cycle can issue the result directly.
    logic             last_slot, cur_free, free_now, cur_match, cur_hit, hit_now;
    logic [IDX_W-1:0] grant_idx, hit_idx;
    logic [IDX_W:0]   qcnt_d;

    assign last_slot = (scan_q == IDX_W'(NUM_SLOTS - 1));
    assign cur_free  = !slot_valid[scan_q];
    assign free_now  = found_q | cur_free;
    assign grant_idx = found_q ? free_idx_q : (cur_free ? scan_q : rr_q);
    assign cur_match = slot_valid[scan_q] && (slot_m[scan_q] == qm_q) && (slot_n[scan_q] == qn_q);
    assign qcnt_d    = qcnt_q + {{IDX_W{1'b0}}, cur_match};
    assign cur_hit   = cur_match && (qcnt_d == (IDX_W+1)'(qidx_q));
    assign hit_now   = qhit_q | cur_hit;
    assign hit_idx   = qhit_q ? qhit_idx_q : scan_q;

    // Table write strobes: clears, victim eviction and commit.
    logic clr_all_en, victim_en, commit_en;
    always_comb begin
        clr_all_en = clear_all && (state_q == IDLE || state_q == FILL);
        victim_en  = (state_q == A_SCAN) && last_slot && !free_now;
        commit_en  = (state_q == FILL) && commit && !abort;
        slot_set   = '0;
        slot_clr   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_clr[i] = clr_all_en || (victim_en && (rr_q == IDX_W'(i)));
            slot_set[i] = commit_en && (pend_idx_q == IDX_W'(i));
        end
    end

    // Popcount of the next-state valid bits keeps mat_count in step with the table.
    logic [4:0] mat_count_d;
    always_comb begin
        mat_count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            mat_count_d = mat_count_d + 5'(slot_valid_d[i]);
    end

    // Valid-slot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mat_count_q <= '0;
        else        mat_count_q <= mat_count_d;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            scan_q       <= '0;
            free_idx_q   <= '0;
            found_q      <= 1'b0;
            rr_q         <= '0;
            pend_idx_q   <= '0;
            pend_m_q     <= '0;
            pend_n_q     <= '0;
            qm_q         <= '0;
            qn_q         <= '0;
            qidx_q       <= '0;
            qcnt_q       <= '0;
            qhit_q       <= 1'b0;
            qhit_idx_q   <= '0;
            addr_ready_q <= 1'b0;
            base_addr_q  <= '0;
            q_done_q     <= 1'b0;
            q_found_q    <= 1'b0;
            q_base_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            addr_ready_q <= 1'b0;
            q_done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    // clear_all is applied through the table strobes.
                    if (!clear_all && alloc_req) begin
                        state_q <= A_SCAN;
                        busy_q  <= 1'b1;
                        scan_q  <= '0;
                        found_q <= 1'b0;
                    end else if (!clear_all && q_req) begin
                        state_q <= Q_SCAN;
                        busy_q  <= 1'b1;
                        scan_q  <= '0;
                        qm_q    <= q_m;
                        qn_q    <= q_n;
                        qidx_q  <= q_idx;
                        qcnt_q  <= '0;
                        qhit_q  <= 1'b0;
                    end
                end
                A_SCAN: begin
                    if (cur_free && !found_q) begin
                        found_q    <= 1'b1;
                        free_idx_q <= scan_q;
                    end
                    scan_q <= scan_q + 1'b1;
                    if (last_slot) begin
                        state_q      <= GRANT;
                        addr_ready_q <= 1'b1;
                        base_addr_q  <= slot_base(grant_idx);
                        pend_idx_q   <= grant_idx;
                        if (!free_now) rr_q <= rr_q + 1'b1;
                    end
                end
                GRANT: begin
                    // Requester is still holding its shape while it sees the grant.
                    pend_m_q <= alloc_m;
                    pend_n_q <= alloc_n;
                    state_q  <= FILL;
                end
                FILL: begin
                    if (commit || abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                Q_SCAN: begin
                    qcnt_q <= qcnt_d;
                    if (cur_hit && !qhit_q) begin
                        qhit_q     <= 1'b1;
                        qhit_idx_q <= scan_q;
                    end
                    scan_q <= scan_q + 1'b1;
                    if (last_slot) begin
                        state_q   <= Q_DONE;
                        q_done_q  <= 1'b1;
                        q_found_q <= hit_now;
                        q_base_q  <= hit_now ? slot_base(hit_idx) : '0;
                    end
                end
                Q_DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_ready = addr_ready_q;
    assign base_addr  = base_addr_q;
    assign q_done     = q_done_q;
    assign q_found    = q_found_q;
    assign q_base     = q_base_q;
    assign busy       = busy_q;
    assign mat_count  = mat_count_q;
endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed bench for matrix_slot_allocator with hand-computed expectations.
module tb_matrix_slot_allocator;
    logic       clk, rst_n;
    logic       alloc_req, commit, abort, clear_all, q_req;
    logic [2:0] alloc_m, alloc_n, q_m, q_n;
    logic [1:0] q_idx;
    logic       addr_ready, q_done, q_found, busy;
    logic [8:0] base_addr, q_base;
    logic [4:0] mat_count;

    int vec = 0;
    int err = 0;
    int qdone_seen = 0;
    int ar_seen = 0;

    matrix_slot_allocator dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .commit(commit), .abort(abort), .clear_all(clear_all),
        .q_req(q_req), .q_m(q_m), .q_n(q_n), .q_idx(q_idx),
        .addr_ready(addr_ready), .base_addr(base_addr),
        .q_done(q_done), .q_found(q_found), .q_base(q_base),
        .busy(busy), .mat_count(mat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q_done) qdone_seen++;
        if (addr_ready) ar_seen++;
    end

    // Drive an allocation until the grant; leaves the DUT in FILL.
    task automatic do_alloc(input logic [2:0] m, input logic [2:0] n,
                            output logic [8:0] base, output logic [4:0] cnt, output int lat);
        lat = -1; base = '0; cnt = '0;
        @(negedge clk); alloc_req = 1'b1; alloc_m = m; alloc_n = n;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (addr_ready) begin lat = c; base = base_addr; cnt = mat_count; break; end
        end
        @(negedge clk); alloc_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_commit();
        @(negedge clk); commit = 1'b1;
        @(posedge clk); #1; commit = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear_all = 1'b1;
        @(posedge clk); #1; clear_all = 1'b0;
    endtask

    task automatic do_query(input logic [2:0] m, input logic [2:0] n, input logic [1:0] idx,
                            output logic found, output logic [8:0] base, output int lat);
        lat = -1; found = 1'b0; base = '0;
        @(negedge clk); q_req = 1'b1; q_m = m; q_n = n; q_idx = idx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1; q_req = 1'b0;
            if (q_done) begin lat = c; found = q_found; base = q_base; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        alloc_req = 0; commit = 0; abort = 0; clear_all = 0; q_req = 0;
        alloc_m = 0; alloc_n = 0; q_m = 0; q_n = 0; q_idx = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if ({addr_ready, base_addr, q_done, q_found, q_base, busy, mat_count} !== '0) begin
            err++; $display("FAIL reset_outputs: got ar=%0b ba=%0d qd=%0b qf=%0b qb=%0d busy=%0b cnt=%0d required all 0",
                            addr_ready, base_addr, q_done, q_found, q_base, busy, mat_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alloc_basic();
        logic [8:0] b; logic [4:0] c; int lat;
        do_alloc(3'd2, 3'd3, b, c, lat);
        vec++; if (lat !== 17) begin err++; $display("FAIL alloc_latency: got %0d required 17", lat); end
        vec++; if (b !== 9'd0) begin err++; $display("FAIL alloc_base0: got %0d required 0", b); end
        vec++; if (busy !== 1'b1) begin err++; $display("FAIL busy_in_fill: got %0b required 1", busy); end
        do_commit();
        vec++; if (mat_count !== 5'd1) begin err++; $display("FAIL commit_count: got %0d required 1", mat_count); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL busy_after_commit: got %0b required 0", busy); end
    endtask

    task automatic test_query();
        logic [8:0] b; logic [4:0] c; int lat; logic f;
        do_clear();
        vec++; if (mat_count !== 5'd0) begin err++; $display("FAIL clear_count: got %0d required 0", mat_count); end
        do_alloc(3'd2, 3'd3, b, c, lat); do_commit();
        do_alloc(3'd3, 3'd3, b, c, lat); do_commit();
        do_alloc(3'd2, 3'd3, b, c, lat); do_commit();
        vec++; if (b !== 9'd50) begin err++; $display("FAIL third_base: got %0d required 50", b); end
        do_query(3'd2, 3'd3, 2'd2, f, b, lat);
        vec++; if (lat !== 17) begin err++; $display("FAIL query_latency: got %0d required 17", lat); end
        vec++; if (f !== 1'b1 || b !== 9'd50) begin err++; $display("FAIL query_2x3_idx2: got found=%0b base=%0d required 1/50", f, b); end
        vec++; if (q_found !== 1'b1 || q_base !== 9'd50) begin err++; $display("FAIL query_held: got found=%0b base=%0d required 1/50", q_found, q_base); end
        do_query(3'd2, 3'd3, 2'd3, f, b, lat);
        vec++; if (f !== 1'b0 || b !== 9'd0) begin err++; $display("FAIL query_2x3_idx3: got found=%0b base=%0d required 0/0", f, b); end
        do_query(3'd3, 3'd3, 2'd1, f, b, lat);
        vec++; if (f !== 1'b1 || b !== 9'd25) begin err++; $display("FAIL query_3x3_idx1: got found=%0b base=%0d required 1/25", f, b); end
        do_query(3'd2, 3'd3, 2'd0, f, b, lat);
        vec++; if (f !== 1'b0 || b !== 9'd0) begin err++; $display("FAIL query_idx0: got found=%0b base=%0d required 0/0", f, b); end
    endtask

    task automatic test_full_table();
        logic [8:0] b; logic [4:0] c; int lat;
        for (int s = 3; s < 16; s++) begin
            do_alloc(3'd1, 3'd1, b, c, lat); do_commit();
            vec++; if (b !== 9'(s * 25)) begin err++; $display("FAIL fill_base_%0d: got %0d required %0d", s, b, s * 25); end
        end
        vec++; if (mat_count !== 5'd16) begin err++; $display("FAIL full_count: got %0d required 16", mat_count); end
        do_alloc(3'd4, 3'd4, b, c, lat);
        vec++; if (b !== 9'd0 || c !== 5'd15) begin err++; $display("FAIL victim0: got base=%0d cnt=%0d required 0/15", b, c); end
        do_commit();
        do_alloc(3'd4, 3'd4, b, c, lat);
        vec++; if (b !== 9'd25 || c !== 5'd15) begin err++; $display("FAIL victim1: got base=%0d cnt=%0d required 25/15", b, c); end
        do_commit();
        vec++; if (mat_count !== 5'd16) begin err++; $display("FAIL refill_count: got %0d required 16", mat_count); end
    endtask

    task automatic test_abort();
        logic [8:0] b; logic [4:0] c; int lat;
        do_alloc(3'd5, 3'd5, b, c, lat);
        vec++; if (b !== 9'd50) begin err++; $display("FAIL victim2: got %0d required 50", b); end
        do_abort();
        vec++; if (mat_count !== 5'd15 || busy !== 1'b0) begin err++; $display("FAIL abort_state: got cnt=%0d busy=%0b required 15/0", mat_count, busy); end
        do_alloc(3'd5, 3'd5, b, c, lat);
        vec++; if (b !== 9'd50) begin err++; $display("FAIL realloc_same: got %0d required 50", b); end
        do_commit();
        // Full again; victim is slot 3. commit+abort together must abort.
        do_alloc(3'd5, 3'd5, b, c, lat);
        vec++; if (b !== 9'd75) begin err++; $display("FAIL victim3: got %0d required 75", b); end
        @(negedge clk); commit = 1'b1; abort = 1'b1;
        @(posedge clk); #1; commit = 1'b0; abort = 1'b0;
        vec++; if (mat_count !== 5'd15 || busy !== 1'b0) begin err++; $display("FAIL commit_abort: got cnt=%0d busy=%0b required 15/0", mat_count, busy); end
    endtask

    task automatic test_alloc_wins();
        logic [8:0] b; int lat; logic f;
        qdone_seen = 0;
        lat = -1; b = '0;
        @(negedge clk); alloc_req = 1'b1; alloc_m = 3'd4; alloc_n = 3'd5;
        q_req = 1'b1; q_m = 3'd2; q_n = 3'd3; q_idx = 2'd1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1; q_req = 1'b0;
            if (addr_ready) begin lat = c; b = base_addr; break; end
        end
        @(negedge clk); alloc_req = 1'b0;
        @(posedge clk); #1;
        vec++; if (lat !== 17 || b !== 9'd75) begin err++; $display("FAIL alloc_over_query: got lat=%0d base=%0d required 17/75", lat, b); end
        @(negedge clk); q_req = 1'b1;
        @(posedge clk); #1; q_req = 1'b0;
        vec++; if (busy !== 1'b1) begin err++; $display("FAIL q_req_in_fill: got busy=%0b required 1", busy); end
        do_clear();
        vec++; if (mat_count !== 5'd0 || busy !== 1'b1) begin err++; $display("FAIL clear_in_fill: got cnt=%0d busy=%0b required 0/1", mat_count, busy); end
        do_commit();
        vec++; if (mat_count !== 5'd1) begin err++; $display("FAIL commit_after_clear: got %0d required 1", mat_count); end
        repeat (20) @(posedge clk);
        #1;
        vec++; if (qdone_seen !== 0) begin err++; $display("FAIL dropped_query: got %0d q_done pulses required 0", qdone_seen); end
        do_query(3'd4, 3'd5, 2'd1, f, b, lat);
        vec++; if (f !== 1'b1 || b !== 9'd75) begin err++; $display("FAIL query_pending_shape: got found=%0b base=%0d required 1/75", f, b); end
    endtask

    task automatic test_reset_mid_scan();
        logic [8:0] b; logic [4:0] c; int lat;
        @(negedge clk); alloc_req = 1'b1; alloc_m = 3'd1; alloc_n = 3'd1;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        vec++; if ({addr_ready, base_addr, q_done, q_found, q_base, busy, mat_count} !== '0) begin
            err++; $display("FAIL async_reset: got ar=%0b ba=%0d qd=%0b qf=%0b qb=%0d busy=%0b cnt=%0d required all 0",
                            addr_ready, base_addr, q_done, q_found, q_base, busy, mat_count);
        end
        alloc_req = 1'b0;
        @(negedge clk); rst_n = 1'b1; ar_seen = 0;
        repeat (25) @(posedge clk);
        #1;
        vec++; if (ar_seen !== 0 || mat_count !== 5'd0 || busy !== 1'b0) begin
            err++; $display("FAIL post_reset_idle: got grants=%0d cnt=%0d busy=%0b required 0/0/0", ar_seen, mat_count, busy);
        end
        do_alloc(3'd2, 3'd2, b, c, lat);
        vec++; if (b !== 9'd0 || lat !== 17) begin err++; $display("FAIL fresh_alloc: got base=%0d lat=%0d required 0/17", b, lat); end
        do_commit();
    endtask

    initial begin
        test_reset();
        test_alloc_basic();
        test_query();
        test_full_table();
        test_abort();
        test_alloc_wins();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
